// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - sequencing controller for the 6-bit four-function calculator datapath
// Optional remainder output o_rem is enabled with `define CALC_SEQ_REM_EN.
module calc_seq_ctrl #(
   parameter int DW = 6
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic [1:0]      i_op,
   input  logic [DW-1:0]   i_data1,
   input  logic [DW-1:0]   i_data2,
   output logic            o_ready,
   output logic            o_busy,
   output logic            o_valid,
   input  logic            i_ack,
   output logic [2*DW-1:0] o_result,
`ifdef CALC_SEQ_REM_EN
   output logic [DW-1:0]   o_rem,
`endif
   output logic            o_err
);

   localparam int CW = $clog2(DW);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DW-1:0]     dvd_q, dvd_d;
   logic [DW-1:0]     dvs_q, dvs_d;
   logic [DW-1:0]     rem_q, rem_d;
   logic [DW-1:0]     quo_q, quo_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*DW-1:0]   result_q, result_d;
   logic              err_q, err_d;
`ifdef CALC_SEQ_REM_EN
   logic [DW-1:0]     rem_out_q, rem_out_d;
`endif

   logic [DW:0]       sum;
   logic [DW:0]       diff;
   logic [2*DW-1:0]   prod;
   logic [DW:0]       trial;
   logic [DW:0]       trial_sub;
   logic              trial_ge;
   logic [DW-1:0]     rem_next;
   logic [DW-1:0]     quo_next;

   always_comb begin
      sum  = {1'b0, i_data1} + {1'b0, i_data2};
      diff = {1'b0, i_data1} - {1'b0, i_data2};
      prod = {{DW{1'b0}}, i_data1} * {{DW{1'b0}}, i_data2};
   end

   // The trial remainder keeps one extra bit so a remainder >= 2^(DW-1) is not lost on the shift.
   always_comb begin
      trial     = {rem_q, dvd_q[DW-1]};
      trial_sub = trial - {1'b0, dvs_q};
      trial_ge  = (trial >= {1'b0, dvs_q});
      rem_next  = trial_ge ? trial_sub[DW-1:0] : trial[DW-1:0];
      quo_next  = {quo_q[DW-2:0], trial_ge};
   end

   always_comb begin
      state_d  = state_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      err_d    = err_q;
`ifdef CALC_SEQ_REM_EN
      rem_out_d = rem_out_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = S_DONE;
               err_d   = 1'b0;
`ifdef CALC_SEQ_REM_EN
               rem_out_d = '0;
`endif
               case (i_op)
                  OP_ADD: result_d = {{(DW-1){1'b0}}, sum};
                  OP_SUB: result_d = {{(DW-1){diff[DW]}}, diff};
                  OP_MUL: result_d = prod;
                  default: begin
                     if (i_data2 == '0) begin
                        result_d = {{DW{1'b0}}, {DW{1'b1}}};
                        err_d    = 1'b1;
`ifdef CALC_SEQ_REM_EN
                        rem_out_d = i_data1;
`endif
                     end else begin
                        state_d = S_EXEC;
                        dvd_d   = i_data1;
                        dvs_d   = i_data2;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = CW'(DW - 1);
                     end
                  end
               endcase
            end
         end
         S_EXEC: begin
            dvd_d = {dvd_q[DW-2:0], 1'b0};
            rem_d = rem_next;
            quo_d = quo_next;
            cnt_d = cnt_q - 1'b1;
            // The final iteration writes the result directly so DONE starts with it in place.
            if (cnt_q == '0) begin
               state_d  = S_DONE;
               result_d = {{DW{1'b0}}, quo_next};
               err_d    = 1'b0;
`ifdef CALC_SEQ_REM_EN
               rem_out_d = rem_next;
`endif
            end
         end
         S_DONE: begin
            if (i_ack) begin
               state_d  = S_IDLE;
               result_d = '0;
               err_d    = 1'b0;
`ifdef CALC_SEQ_REM_EN
               rem_out_d = '0;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
`ifdef CALC_SEQ_REM_EN
         rem_out_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         err_q    <= err_d;
`ifdef CALC_SEQ_REM_EN
         rem_out_q <= rem_out_d;
`endif
      end
   end

   assign o_ready  = (state_q == S_IDLE);
   assign o_busy   = (state_q == S_EXEC);
   assign o_valid  = (state_q == S_DONE);
   assign o_result = result_q;
   assign o_err    = err_q;
`ifdef CALC_SEQ_REM_EN
   assign o_rem    = rem_out_q;
`endif

endmodule
